id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/alu_ctrl_dec.sv | 35 +++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared ALUOp, funct and ALU control encodings plus the ID/EX
//               control-bundle layout and the forwarding match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // ALUOp field driven by the main decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   // R-type funct field values understood by the ALU
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;

   // ALU operation codes
   localparam logic [3:0] ALUC_AND     = 4'b0000;
   localparam logic [3:0] ALUC_OR      = 4'b0001;
   localparam logic [3:0] ALUC_ADD     = 4'b0010;
   localparam logic [3:0] ALUC_SUB     = 4'b0110;
   localparam logic [3:0] ALUC_INVALID = 4'b1111;

   // Control bundle as delivered by ID, MSB first
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_src;
      logic reg_dst;
   } id_ctrl_t;

   // A later stage may forward to an index only when it writes that same,
   // non-zero register; register 0 is hard-wired and never forwarded.
   function automatic logic fwd_match(input logic       we,
                                      input logic [4:0] dst,
                                      input logic [4:0] idx);
      return we && (dst == idx) && (idx != 5'd0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : Decodes ALUOp and funct into the 4-bit ALU operation code.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
   import mips_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control
);

   // Unsupported ALUOp/funct combinations map to the invalid code
   always_comb begin
      alu_control = ALUC_INVALID;
      case (alu_op)
         ALUOP_ADD: alu_control = ALUC_ADD;
         ALUOP_SUB: alu_control = ALUC_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: alu_control = ALUC_ADD;
               FUNCT_SUB: alu_control = ALUC_SUB;
               FUNCT_AND: alu_control = ALUC_AND;
               FUNCT_OR:  alu_control = ALUC_OR;
               default:   alu_control = ALUC_INVALID;
            endcase
         end
         default: alu_control = ALUC_INVALID;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with stall/flush, ALU control decode,
//               EX-stage operand forwarding and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [5:0]        id_ctrl,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              mem_fwd_we,
   input  logic [4:0]        mem_fwd_rd,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic              wb_fwd_we,
   input  logic [4:0]        wb_fwd_rd,
   input  logic [DATA_W-1:0] wb_fwd_data,
   output logic              ex_valid,
   output logic [3:0]        ex_ctrl,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_control,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [4:0]        ex_write_reg,
   output logic              load_use_hazard
);

   logic              valid_q,   valid_d;
   id_ctrl_t          ctrl_q,    ctrl_d;
   logic [1:0]        alu_op_q,  alu_op_d;
   logic [5:0]        funct_q,   funct_d;
   logic [4:0]        rs_q,      rs_d;
   logic [4:0]        rt_q,      rt_d;
   logic [4:0]        rd_q,      rd_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q,     imm_d;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Next-state: flush inserts a bubble (wins over stall), stall holds, else load
   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      alu_op_d  = alu_op_q;
      funct_d   = funct_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (!stall) begin
         valid_d   = id_valid;
         ctrl_d    = id_ctrl_t'(id_ctrl);
         alu_op_d  = id_alu_op;
         funct_d   = id_funct;
         rs_d      = id_rs;
         rt_d      = id_rt;
         rd_d      = id_rd;
         rs_data_d = id_rs_data;
         rt_data_d = id_rt_data;
         imm_d     = id_imm;
      end
   end

   // Pipeline register; reset empties the stage so a bubble follows release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         alu_op_q  <= '0;
         funct_q   <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         alu_op_q  <= alu_op_d;
         funct_q   <= funct_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
      end
   end

   // Operand forwarding: the younger EX/MEM result beats MEM/WB
   always_comb begin
      fwd_rs = rs_data_q;
      if (fwd_match(mem_fwd_we, mem_fwd_rd, rs_q)) begin
         fwd_rs = mem_fwd_data;
      end else if (fwd_match(wb_fwd_we, wb_fwd_rd, rs_q)) begin
         fwd_rs = wb_fwd_data;
      end
      fwd_rt = rt_data_q;
      if (fwd_match(mem_fwd_we, mem_fwd_rd, rt_q)) begin
         fwd_rt = mem_fwd_data;
      end else if (fwd_match(wb_fwd_we, wb_fwd_rd, rt_q)) begin
         fwd_rt = wb_fwd_data;
      end
   end

   // Datapath outputs and load-use detection against the instruction in ID
   always_comb begin
      ex_valid        = valid_q;
      ex_ctrl         = valid_q ? {ctrl_q.reg_write, ctrl_q.mem_read,
                                   ctrl_q.mem_write, ctrl_q.mem_to_reg} : 4'b0000;
      alu_a           = fwd_rs;
      alu_b           = ctrl_q.alu_src ? imm_q : fwd_rt;
      ex_store_data   = fwd_rt;
      ex_write_reg    = ctrl_q.reg_dst ? rd_q : rt_q;
      load_use_hazard = valid_q && ctrl_q.mem_read && id_valid &&
                        (ex_write_reg != 5'd0) &&
                        ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));
   end

   alu_ctrl_dec u_alu_ctrl_dec (
      .alu_op      (alu_op_q),
      .funct       (funct_q),
      .alu_control (alu_control)
   );

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

   localparam int DATA_W = 32;

   // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
   localparam logic [5:0] CTRL_RTYPE = 6'b100001;
   localparam logic [5:0] CTRL_LW    = 6'b110110;

   logic              clk = 1'b0;
   logic              reset;
   logic              stall, flush, id_valid;
   logic [5:0]        id_ctrl;
   logic [1:0]        id_alu_op;
   logic [5:0]        id_funct;
   logic [4:0]        id_rs, id_rt, id_rd;
   logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
   logic              mem_fwd_we, wb_fwd_we;
   logic [4:0]        mem_fwd_rd, wb_fwd_rd;
   logic [DATA_W-1:0] mem_fwd_data, wb_fwd_data;
   logic              ex_valid;
   logic [3:0]        ex_ctrl;
   logic [DATA_W-1:0] alu_a, alu_b, ex_store_data;
   logic [3:0]        alu_control;
   logic [4:0]        ex_write_reg;
   logic              load_use_hazard;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DATA_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_ctrl         (id_ctrl),
      .id_alu_op       (id_alu_op),
      .id_funct        (id_funct),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_rd           (id_rd),
      .id_rs_data      (id_rs_data),
      .id_rt_data      (id_rt_data),
      .id_imm          (id_imm),
      .mem_fwd_we      (mem_fwd_we),
      .mem_fwd_rd      (mem_fwd_rd),
      .mem_fwd_data    (mem_fwd_data),
      .wb_fwd_we       (wb_fwd_we),
      .wb_fwd_rd       (wb_fwd_rd),
      .wb_fwd_data     (wb_fwd_data),
      .ex_valid        (ex_valid),
      .ex_ctrl         (ex_ctrl),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_control     (alu_control),
      .ex_store_data   (ex_store_data),
      .ex_write_reg    (ex_write_reg),
      .load_use_hazard (load_use_hazard)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [5:0] c, input logic [1:0] op,
                         input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm);
      id_valid   = v;
      id_ctrl    = c;
      id_alu_op  = op;
      id_funct   = fn;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_rs_data = rsd;
      id_rt_data = rtd;
      id_imm     = imm;
   endtask

   task automatic fwd_off();
      mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = '0;
      wb_fwd_we  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = '0;
   endtask

   // Load an R-type/ALUOp combination and check the decoded ALU code
   task automatic dec_case(input string tag, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] exp);
      set_id(1'b1, CTRL_RTYPE, op, fn, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0);
      tick();
      chk(tag, {28'd0, alu_control}, {28'd0, exp});
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      set_id(1'b0, 6'd0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
      fwd_off();

      // Reset state
      #3;
      chk("rst_valid",  {31'd0, ex_valid}, 32'd0);
      chk("rst_ctrl",   {28'd0, ex_ctrl}, 32'd0);
      chk("rst_alu_a",  alu_a, 32'd0);
      chk("rst_aluc",   {28'd0, alu_control}, 32'h2);
      chk("rst_wreg",   {27'd0, ex_write_reg}, 32'd0);
      chk("rst_hazard", {31'd0, load_use_hazard}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // add $10, $8, $9 with rs=5, rt=7
      set_id(1'b1, CTRL_RTYPE, 2'b10, 6'b100000, 5'd8, 5'd9, 5'd10, 32'd5, 32'd7, 32'h1234);
      tick();
      chk("add_alu_a",  alu_a, 32'd5);
      chk("add_alu_b",  alu_b, 32'd7);
      chk("add_aluc",   {28'd0, alu_control}, 32'h2);
      chk("add_valid",  {31'd0, ex_valid}, 32'd1);
      chk("add_ctrl",   {28'd0, ex_ctrl}, 32'h8);
      chk("add_wreg",   {27'd0, ex_write_reg}, 32'd10);
      chk("add_store",  ex_store_data, 32'd7);

      // Forwarding priority on registered rs=8, rt=9 (stage held)
      stall = 1'b1;
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd8; mem_fwd_data = 32'h11;
      wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd8; wb_fwd_data  = 32'h22;
      #1;
      chk("fwd_both_a", alu_a, 32'h11);
      chk("fwd_both_b", alu_b, 32'd7);
      mem_fwd_we = 1'b0;
      #1;
      chk("fwd_wb_a", alu_a, 32'h22);
      wb_fwd_rd = 5'd9;
      #1;
      chk("fwd_wb_rt_a", alu_a, 32'd5);
      chk("fwd_wb_rt_b", alu_b, 32'h22);
      chk("fwd_wb_st",   ex_store_data, 32'h22);
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd9;
      #1;
      chk("fwd_mem_rt_b", alu_b, 32'h11);
      fwd_off();
      stall = 1'b0;

      // ALU control decode table
      dec_case("dec_sub",  2'b10, 6'b100010, 4'b0110);
      dec_case("dec_and",  2'b10, 6'b100100, 4'b0000);
      dec_case("dec_or",   2'b10, 6'b100101, 4'b0001);
      dec_case("dec_bad",  2'b10, 6'b101010, 4'b1111);
      dec_case("dec_op00", 2'b00, 6'b100010, 4'b0010);
      dec_case("dec_op01", 2'b01, 6'b100000, 4'b0110);
      dec_case("dec_op11", 2'b11, 6'b100000, 4'b1111);

      // Register 0 is never forwarded
      set_id(1'b1, CTRL_RTYPE, 2'b10, 6'b100000, 5'd0, 5'd3, 5'd4, 32'h33, 32'h44, 32'd0);
      tick();
      mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFF;
      wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hEE;
      #1;
      chk("zero_alu_a", alu_a, 32'h33);
      fwd_off();

      // lw $4, 8($1): immediate operand and load-use detection
      set_id(1'b1, CTRL_LW, 2'b00, 6'd0, 5'd1, 5'd4, 5'd7, 32'd100, 32'h55, 32'd8);
      tick();
      chk("lw_alu_a",  alu_a, 32'd100);
      chk("lw_alu_b",  alu_b, 32'd8);
      chk("lw_store",  ex_store_data, 32'h55);
      chk("lw_wreg",   {27'd0, ex_write_reg}, 32'd4);
      chk("lw_ctrl",   {28'd0, ex_ctrl}, 32'hD);
      set_id(1'b1, CTRL_RTYPE, 2'b10, 6'b100000, 5'd4, 5'd5, 5'd6, 32'd0, 32'd0, 32'd0);
      #1;
      chk("lu_rs", {31'd0, load_use_hazard}, 32'd1);
      id_rs = 5'd5; id_rt = 5'd4;
      #1;
      chk("lu_rt", {31'd0, load_use_hazard}, 32'd1);
      id_valid = 1'b0;
      #1;
      chk("lu_noval", {31'd0, load_use_hazard}, 32'd0);
      id_valid = 1'b1; id_rt = 5'd6;
      #1;
      chk("lu_nomatch", {31'd0, load_use_hazard}, 32'd0);
      id_rt = 5'd4;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("lu_fl_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_fl_ctrl",  {28'd0, ex_ctrl}, 32'd0);
      chk("lu_fl_haz",   {31'd0, load_use_hazard}, 32'd0);

      // Load to $0 never raises a hazard
      set_id(1'b1, CTRL_LW, 2'b00, 6'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd4);
      tick();
      set_id(1'b1, CTRL_RTYPE, 2'b10, 6'b100000, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0);
      #1;
      chk("lu_zero", {31'd0, load_use_hazard}, 32'd0);

      // Stall alone for 3 cycles holds everything
      set_id(1'b1, CTRL_RTYPE, 2'b10, 6'b100010, 5'd8, 5'd9, 5'd10, 32'd5, 32'd7, 32'd0);
      tick();
      set_id(1'b1, CTRL_LW, 2'b00, 6'd0, 5'd2, 5'd3, 5'd11, 32'h99, 32'h98, 32'h97);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_alu_a", alu_a, 32'd5);
         chk("stall_alu_b", alu_b, 32'd7);
         chk("stall_aluc",  {28'd0, alu_control}, 32'h6);
         chk("stall_wreg",  {27'd0, ex_write_reg}, 32'd10);
         chk("stall_ctrl",  {28'd0, ex_ctrl}, 32'h8);
      end

      // Stall and flush together give a bubble
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sf_valid", {31'd0, ex_valid}, 32'd0);
      chk("sf_ctrl",  {28'd0, ex_ctrl}, 32'd0);

      // Asynchronous reset in the middle of a stall
      stall = 1'b0;
      tick();
      chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
      stall = 1'b1;
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("ar_valid", {31'd0, ex_valid}, 32'd0);
      chk("ar_ctrl",  {28'd0, ex_ctrl}, 32'd0);
      chk("ar_alu_a", alu_a, 32'd0);
      chk("ar_alu_b", alu_b, 32'd0);
      chk("ar_aluc",  {28'd0, alu_control}, 32'h2);
      chk("ar_wreg",  {27'd0, ex_write_reg}, 32'd0);
      chk("ar_store", ex_store_data, 32'd0);
      #1;
      reset = 1'b0;
      tick();
      chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("post_rst_ctrl",  {28'd0, ex_ctrl}, 32'd0);
      stall = 1'b0;
      tick();
      chk("resume_valid", {31'd0, ex_valid}, 32'd1);
      chk("resume_alu_a", alu_a, 32'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
